// File: rtl/controlador_banco_reg_pkg.sv
// Shared types and constants for the register-bank write controller.
package ctrl_banco_pkg;

  localparam int unsigned W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/controlador_banco_reg_if.sv
// Requester/read bus between producers and the register-bank controller.
interface controlador_banco_reg_if
  import ctrl_banco_pkg::*;
#(
  parameter int unsigned NREG = 4,
  parameter int unsigned W    = W_DEF
);
  localparam int unsigned AW = $clog2(NREG);

  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [W-1:0]  d0;
  logic [W-1:0]  d1;
  logic          ack0;
  logic          ack1;
  logic [AW-1:0] raddr;
  logic [W-1:0]  rdata;
  logic          busy;

  modport master (
    output req0, req1, addr0, addr1, d0, d1, raddr,
    input  ack0, ack1, rdata, busy
  );

  modport slave (
    input  req0, req1, addr0, addr1, d0, d1, raddr,
    output ack0, ack1, rdata, busy
  );

endinterface

// File: rtl/controlador_banco_reg_registrador_16b_rst.sv
// W-bit load-enable register with asynchronous active-low clear.
module registrador_16b_rst
  import ctrl_banco_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         l_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  q_q <= '0;
    else if (l_i)  q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/controlador_banco_reg.sv
// Two-requester round-robin write controller for a bank of load-enable registers,
// with a combinational read port.
module controlador_banco_reg
  import ctrl_banco_pkg::*;
#(
  parameter int unsigned NREG = 4,
  parameter int unsigned W    = W_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  controlador_banco_reg_if.slave  bus
);

  localparam int unsigned AW = $clog2(NREG);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_ACK  = ACK;

  logic [1:0]    state_q, state_d;
  logic          prio_q, prio_d;
  logic          win_q, win_d;
  logic [AW-1:0] cap_addr_q, cap_addr_d;
  logic [W-1:0]  cap_data_q, cap_data_d;

  logic          gnt1;
  logic [NREG-1:0] load;
  logic [W-1:0]  bank [NREG];

  // Requester 1 wins when alone, or when both ask and it holds priority.
  assign gnt1 = bus.req1 & (~bus.req0 | prio_q);

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    win_d      = win_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          win_d      = gnt1;
          cap_addr_d = gnt1 ? bus.addr1 : bus.addr0;
          cap_data_d = gnt1 ? bus.d1 : bus.d0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: state_d = S_ACK;
      S_ACK: begin
        prio_d  = ~win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      win_q      <= 1'b0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      win_q      <= win_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_bank
    assign load[i] = (state_q == S_LOAD) && (cap_addr_q == AW'(i));

    registrador_16b_rst #(.W(W)) u_reg (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .l_i     (load[i]),
      .d_i     (cap_data_q),
      .q_o     (bank[i])
    );
  end

  // Acks decode from registered state so an async reset drops them at once.
  assign bus.ack0  = (state_q == S_ACK) && !win_q;
  assign bus.ack1  = (state_q == S_ACK) &&  win_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.rdata = bank[bus.raddr];

endmodule
